min_max_peak: RTL
=================

MIN_MAX_PEAK -- requirements
Module: min_max_peak

Interface
REQ-001 Parameter VALSIZE, default 4, value width; leds_o is 2**VALSIZE wide.
REQ-002 Parameter BLINK_HALF, default 4, blink half-period in clk_i cycles (>=1).
REQ-003 Parameter HOLD_CYCLES, default 8, peak hold time in clk_i cycles (>=1).
REQ-004 Port clk_i, in, 1, single clock, rising-edge active.
REQ-005 Port rst_ni, in, 1, asynchronous, active-low reset.
REQ-006 Port com_i, in, 3, mode: 000 normal, 001 linear, 010 all off, 011 all on, 100 peak; 101-111 treated as all off.
REQ-007 Port valid_i, in, 1, sample strobe for com_i/min_i/max_i/val_i.
REQ-008 Port min_i, in, VALSIZE, lower bound of the bar.
REQ-009 Port max_i, in, VALSIZE, upper bound of the bar.
REQ-010 Port val_i, in, VALSIZE, displayed value.
REQ-011 Port leds_o, out, 2**VALSIZE, registered LED pattern.
REQ-012 Port err_o, out, 1, registered flag: captured min > max.

Function
REQ-013 On a clk_i edge with valid_i=1, com/min/max/val are captured into registers; with valid_i=0, the registers hold.
REQ-014 leds_o and err_o are registered: a capture at edge N is reflected at edge N+1; the blink and peak state at edge N+1 also apply.
REQ-015 Internal blink generator: counter 0..BLINK_HALF-1, free-running in all modes; osc toggles when the counter wraps from BLINK_HALF-1 to 0.
REQ-016 Normal mode, min<=val<=max: bits min..val=1; bits val+1..max=osc; all other bits 0.
REQ-017 Normal mode, val<min or val>max: leds_o=0.
REQ-018 Linear mode: bits 0..val=1, all others 0, regardless of min/max.
REQ-019 All-off: leds_o=0. All-on: leds_o all ones.
REQ-020 Peak mode: normal-mode pattern OR bit[peak]=1.
REQ-021 Peak FSM has two states. HOLD: the hold counter increments each cycle; at HOLD_CYCLES-1 the FSM goes to DECAY. DECAY: peak decrements by 1 each cycle; when peak equals max(val, min), the FSM returns to HOLD and the counter clears.
REQ-022 A captured val with min<=val<=max and val>peak sets peak=val, clears the hold counter and forces HOLD; this takes priority over a simultaneous decay step.
REQ-023 Outside peak mode, peak equals the captured val, the FSM stays in HOLD and the hold counter is 0.
REQ-024 err_o=1 whenever captured min>max. In that case leds_o=0 in normal and peak modes, and peak and the FSM freeze. Linear, all-off and all-on modes are unaffected by err_o.
REQ-025 Only unsigned arithmetic is used. The peak decrement never goes below min and never wraps.

Reset
REQ-026 While rst_ni=0 (asynchronous): leds_o=0, err_o=0, captured registers=0 (com=000), peak=0, FSM=HOLD, hold counter=0, blink counter=0, osc=0.
REQ-027 Reset asserted mid-operation, including during DECAY, clears all state immediately. The first capture is the first edge after release with valid_i=1.

Structure
REQ-028 Package min_max_pkg holds the com_i mode encoding (enum), the peak FSM state typedef (HOLD, DECAY) and the mode constants.
REQ-029 The blink generator is a sub-module min_max_blink, parametrised by BLINK_HALF, with outputs osc and wrap.
REQ-030 The LED pattern is computed combinationally from the captured registers, osc and peak, then registered once.

Verification
REQ-031 Reset, then com=011 valid for 1 cycle -> leds_o=0 during reset; leds_o=0xFFFF one cycle after the capture edge; err_o=0.
REQ-032 Normal, min=3 max=12 val=8 -> bits 3..8 steady 1; bits 9..12 toggle every 4 cycles, starting at 0 after reset; other bits 0.
REQ-033 Linear, val=5, min=9 max=3 -> leds_o=0x003F; err_o=1.
REQ-034 Peak, min=0 max=15: val=10, then val=4 -> bit10 lit for 8 cycles; bits 9,8,7,6,5 then lit one per cycle; afterwards only bar bits 0..4 are lit. A val=12 injected during decay -> bit12 lit immediately and the hold restarts.
REQ-035 Normal, min=9 max=3 val=5 -> err_o=1 and leds_o=0; then min=2 max=9 -> err_o=0 and bar pattern is shown next cycle.
REQ-036 rst_ni pulsed low during DECAY -> all outputs 0 within the same cycle; after release, behaviour matches REQ-031.

Source files
------------

// File: rtl/min_max_pkg.sv
// Shared encodings for the min/max/peak LED bar: command modes and peak FSM states.
package min_max_pkg;
  localparam int COM_W = 3;

  typedef enum logic [COM_W-1:0] {
    COM_NORMAL = 3'b000,
    COM_LINEAR = 3'b001,
    COM_OFF    = 3'b010,
    COM_ON     = 3'b011,
    COM_PEAK   = 3'b100
  } com_e;

  typedef enum logic {
    ST_HOLD  = 1'b0,
    ST_DECAY = 1'b1
  } peak_st_e;
endpackage

// File: rtl/min_max_blink.sv
// Free-running blink generator: osc toggles each time the half-period counter wraps.
module min_max_blink #(
  parameter int BLINK_HALF = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic osc,
  output logic wrap
);
  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] cnt;

  assign wrap = (cnt == CW'(BLINK_HALF - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      osc <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      osc <= ~osc;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/min_max_peak.sv
// LED bar display of a value between min and max, with blink fill and peak-hold/decay marker.
module min_max_peak
  import min_max_pkg::*;
#(
  parameter int VALSIZE     = 4,
  parameter int BLINK_HALF  = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [2:0]            com_i,
  input  logic                  valid_i,
  input  logic [VALSIZE-1:0]    min_i,
  input  logic [VALSIZE-1:0]    max_i,
  input  logic [VALSIZE-1:0]    val_i,
  output logic [2**VALSIZE-1:0] leds_o,
  output logic                  err_o
);
  localparam int W  = 2**VALSIZE;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [2:0]         com_q;
  logic [VALSIZE-1:0] min_q, max_q, val_q;
  logic [VALSIZE-1:0] peak, peak_next, flr;
  logic [HW-1:0]      hold_cnt, hold_next;
  peak_st_e           st, st_next;
  logic               osc, wrap, osc_next;
  logic               err_now, in_range;
  logic [W-1:0]       bar, lin, pk, leds_d;

  min_max_blink #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .osc    (osc),
    .wrap   (wrap)
  );

  // The pattern is registered on the same edge osc advances, so use its next value.
  assign osc_next = osc ^ wrap;
  assign err_now  = (min_q > max_q);
  assign in_range = (min_q <= val_q) && (val_q <= max_q);
  assign flr      = (val_q > min_q) ? val_q : min_q;

  always_comb begin
    peak_next = peak;
    st_next   = st;
    hold_next = hold_cnt;
    if (com_q != COM_PEAK) begin
      peak_next = val_q;
      st_next   = ST_HOLD;
      hold_next = '0;
    end else if (!err_now) begin
      if (in_range && (val_q > peak)) begin
        peak_next = val_q;
        st_next   = ST_HOLD;
        hold_next = '0;
      end else begin
        case (st)
          ST_HOLD:
            if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
              st_next   = ST_DECAY;
              hold_next = '0;
            end else begin
              hold_next = hold_cnt + HW'(1);
            end
          ST_DECAY:
            // flr >= min, so stopping here keeps the decrement from going below min or wrapping.
            if (peak <= flr) begin
              st_next   = ST_HOLD;
              hold_next = '0;
            end else begin
              peak_next = peak - VALSIZE'(1);
            end
          default: st_next = ST_HOLD;
        endcase
      end
    end
  end

  always_comb begin
    bar = '0;
    lin = '0;
    pk  = '0;
    for (int i = 0; i < W; i++) begin
      lin[i] = (i <= int'(val_q));
      if (in_range) begin
        if (i >= int'(min_q) && i <= int'(val_q)) bar[i] = 1'b1;
        else if (i > int'(val_q) && i <= int'(max_q)) bar[i] = osc_next;
      end
    end
    pk[peak_next] = 1'b1;
    case (com_q)
      COM_NORMAL: leds_d = err_now ? '0 : bar;
      COM_LINEAR: leds_d = lin;
      COM_ON:     leds_d = '1;
      COM_PEAK:   leds_d = err_now ? '0 : (bar | pk);
      default:    leds_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      com_q    <= 3'b000;
      min_q    <= '0;
      max_q    <= '0;
      val_q    <= '0;
      peak     <= '0;
      st       <= ST_HOLD;
      hold_cnt <= '0;
      leds_o   <= '0;
      err_o    <= 1'b0;
    end else begin
      if (valid_i) begin
        com_q <= com_i;
        min_q <= min_i;
        max_q <= max_i;
        val_q <= val_i;
      end
      peak     <= peak_next;
      st       <= st_next;
      hold_cnt <= hold_next;
      leds_o   <= leds_d;
      err_o    <= err_now;
    end
  end
endmodule
